// File: rtl/free_list_ctrl.sv
// Free physical-register pool: circular buffer with a speculative alloc head,
// a release tail and a retire head used to reclaim squashed allocations on flush.
module free_list_ctrl #(
  parameter int PRF_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  parameter int PRF_IDX   = $clog2(PRF_DEPTH),
  parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH,
  parameter int FL_IDX    = $clog2(FL_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [PRF_IDX-1:0] alloc_idx,
  input  logic               free_valid,
  input  logic [PRF_IDX-1:0] free_idx,
  input  logic               flush,
  output logic               empty,
  output logic [FL_IDX:0]    free_count
);

  typedef logic [FL_IDX:0] ptr_t;
  localparam ptr_t FULL = ptr_t'(FL_DEPTH);

  ptr_t head, tail, rhead, head_nxt;
  logic [FL_DEPTH-1:0][PRF_IDX-1:0] mem;

  // Full vs empty differ only in the wrap bit, so the subtraction keeps it.
  assign free_count = tail - head;
  assign empty      = (free_count == '0);
  assign alloc_ack  = alloc_req & ~empty & ~flush;
  assign alloc_idx  = mem[head[FL_IDX-1:0]];

  // Flush rewinds to the committed point, counting a same-cycle commit.
  always_comb begin
    head_nxt = head;
    if (flush)          head_nxt = rhead + ptr_t'(free_valid);
    else if (alloc_ack) head_nxt = head + ptr_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      rhead <= '0;
      tail  <= FULL;
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PRF_IDX'(ARF_DEPTH + i);
    end else begin
      head <= head_nxt;
      if (free_valid) begin
        mem[tail[FL_IDX-1:0]] <= free_idx;
        tail  <= tail + ptr_t'(1);
        rhead <= rhead + ptr_t'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(free_valid && free_count == FULL))
    else $error("free_list_ctrl: release into a full free list");

endmodule

// File: tb/tb_free_list_ctrl.sv
// Randomized bench for free_list_ctrl against a queue-based pool/speculative/held model.
module tb_free_list_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_req, alloc_ack, free_valid, flush, empty;
  logic [5:0] alloc_idx, free_idx;
  logic [5:0] free_count;

  free_list_ctrl dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .alloc_idx(alloc_idx), .free_valid(free_valid), .free_idx(free_idx),
    .flush(flush), .empty(empty), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // pool: allocatable in grant order; spec: granted, not yet committed (oldest first);
  // held: committed mappings that commit may release.
  int pool[$];
  int spec[$];
  int held[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    pool.delete(); spec.delete(); held.delete();
    for (int i = 0; i < 32; i++) begin
      pool.push_back(32 + i);
      held.push_back(i);
    end
  endtask

  // Drive one cycle's inputs, check combinational outputs, then advance the model.
  task automatic step(input bit req, input bit fv, input int fidx, input bit fl);
    bit exp_ack;
    bit dup;
    int c;
    int tmp[$];
    @(negedge clk);
    alloc_req  = req;
    free_valid = fv;
    free_idx   = fidx[5:0];
    flush      = fl;
    #1;
    exp_ack = req && (pool.size() > 0) && !fl;
    chk("free_count", int'(free_count), pool.size());
    chk("empty", int'(empty), int'(pool.size() == 0));
    chk("alloc_ack", int'(alloc_ack), int'(exp_ack));
    if (pool.size() > 0) chk("alloc_idx", int'(alloc_idx), pool[0]);
    if (alloc_ack) begin
      dup = 1'b0;
      foreach (spec[k]) if (spec[k] == int'(alloc_idx)) dup = 1'b1;
      foreach (held[k]) if (held[k] == int'(alloc_idx)) dup = 1'b1;
      chk("dup_grant", int'(dup), 0);
    end
    if (fv) begin
      c = spec.pop_front();
      for (int k = 0; k < held.size(); k++)
        if (held[k] == fidx) begin held.delete(k); break; end
      held.push_back(c);
      pool.push_back(fidx);
    end
    if (exp_ack) spec.push_back(pool.pop_front());
    if (fl) begin
      tmp = spec;
      foreach (pool[k]) tmp.push_back(pool[k]);
      pool = tmp;
      spec.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    alloc_req = 0; free_valid = 0; free_idx = '0; flush = 0;
    rst = 1'b1;
    #1;
    chk("rst_count", int'(free_count), 32);
    chk("rst_idx", int'(alloc_idx), 32);
    chk("rst_empty", int'(empty), 0);
    chk("rst_ack", int'(alloc_ack), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
  endtask

  int held_pick;

  initial begin
    rst = 1'b1;
    alloc_req = 0; free_valid = 0; free_idx = '0; flush = 0;
    reset_model();
    do_reset();

    // three allocations from reset, then drain to empty
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    #1 chk("t1_idx34_granted_count", int'(free_count), 30);
    for (int i = 0; i < 29; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t2_last_empty", int'(empty), 1);
    step(1, 0, 0, 0);
    // concurrent free while empty is not bypassed
    step(1, 1, 5, 0);
    chk("t3_nobypass_ack", int'(alloc_ack), 0);
    step(1, 0, 0, 0);
    chk("t3_idx5", int'(alloc_idx), 5);

    // allocate 4, commit 1 (releasing 7), flush
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("t4_idx33", int'(alloc_idx), 33);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // flush together with a commit: alloc_req ignored, head = rhead + 1
    step(1, 1, 9, 1);
    chk("t5_flush_ack", int'(alloc_ack), 0);
    step(0, 0, 0, 0);

    // long random traffic with an async reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, f, fl;
      int fi;
      if (cyc == 1500) do_reset();
      r  = ($urandom_range(0, 99) < 60);
      f  = (spec.size() > 0) && ($urandom_range(0, 99) < 45);
      fl = ($urandom_range(0, 99) < 3);
      fi = 0;
      if (f) begin
        held_pick = $urandom_range(0, held.size() - 1);
        fi = held[held_pick];
      end
      step(r, f, fi, fl);
    end
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
